// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared opcodes, state codes and select encodings for the multicycle MIPS control path
package mips_pkg;

    // Instruction opcodes, instruction register bits [31:26]
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    // ALU operation class handed to the ALU function decoder
    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    // ALU B operand selects
    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    // PC source selects
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Control FSM state codes; 12..15 are unused
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    // True for every opcode the control FSM knows how to sequence
    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: return 1'b1;
            default:                                      return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_ctrl_out_decode.sv
// rtl/mips_ctrl_out_decode.sv - combinational map from control state to datapath enables and selects
module mips_ctrl_out_decode
    import mips_pkg::*;
(
    input  state_t     state,
    input  logic       mem_ready,
    input  logic       zero,
    output logic       ir_write,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src
);

    logic pc_write;
    logic branch;

    // Per-state control word; unlisted outputs stay 0, unused codes decode to all zeros
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        iord       = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        alu_op     = ALU_ADD;
        pc_src     = PCSRC_ALU;
        case (state)
            S_FETCH: begin
                // PC+4 and the IR load only commit once memory returns the word
                mem_req   = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                // Precompute the branch target into ALUOut while decoding
                alu_src_b = SRCB_IMM_SH2;
            end
            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
                pc_src    = PCSRC_ALUOUT;
            end
            S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                reg_write = 1'b1;
            end
            S_JUMP: begin
                pc_src   = PCSRC_JUMP;
                pc_write = 1'b1;
            end
            default: begin
            end
        endcase
        pc_en = pc_write | (branch & zero);
    end

endmodule

// File: rtl/mips_multicycle_controller.sv
// rtl/mips_multicycle_controller.sv - main control FSM of the multicycle MIPS core
module mips_multicycle_controller
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       ir_write,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_req,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       illegal_op,
    output logic [3:0] state
);

    state_t state_q;
    // lw/sw choice captured in DECODE so MEMADR does not depend on a later opcode
    logic   is_store_q;

    logic   d_ir_write;
    logic   d_pc_en;
    logic   d_mem_req;
    logic   d_mem_write;
    logic   d_reg_write;

    // State register and next-state sequencing; reset aborts any instruction at once
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_FETCH;
            is_store_q <= 1'b0;
        end else begin
            case (state_q)
                S_FETCH:   if (mem_ready) state_q <= S_DECODE;
                S_DECODE: begin
                    is_store_q <= (opcode == OP_SW);
                    case (opcode)
                        OP_LW, OP_SW: state_q <= S_MEMADR;
                        OP_RTYPE:     state_q <= S_EXECUTE;
                        OP_BEQ:       state_q <= S_BRANCH;
                        OP_ADDI:      state_q <= S_ADDIEX;
                        OP_J:         state_q <= S_JUMP;
                        default:      state_q <= S_FETCH;
                    endcase
                end
                S_MEMADR:  state_q <= is_store_q ? S_MEMWR : S_MEMRD;
                S_MEMRD:   if (mem_ready) state_q <= S_MEMWB;
                S_MEMWB:   state_q <= S_FETCH;
                S_MEMWR:   if (mem_ready) state_q <= S_FETCH;
                S_EXECUTE: state_q <= S_ALUWB;
                S_ALUWB:   state_q <= S_FETCH;
                S_BRANCH:  state_q <= S_FETCH;
                S_ADDIEX:  state_q <= S_ADDIWB;
                S_ADDIWB:  state_q <= S_FETCH;
                S_JUMP:    state_q <= S_FETCH;
                default:   state_q <= S_FETCH;
            endcase
        end
    end

    mips_ctrl_out_decode u_out_decode (
        .state      (state_q),
        .mem_ready  (mem_ready),
        .zero       (zero),
        .ir_write   (d_ir_write),
        .pc_en      (d_pc_en),
        .iord       (iord),
        .mem_req    (d_mem_req),
        .mem_write  (d_mem_write),
        .reg_write  (d_reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src)
    );

    // FETCH decodes ir_write/pc_en from mem_ready, so enables are held off while reset is low
    assign ir_write   = rst_n & d_ir_write;
    assign pc_en      = rst_n & d_pc_en;
    assign mem_req    = rst_n & d_mem_req;
    assign mem_write  = rst_n & d_mem_write;
    assign reg_write  = rst_n & d_reg_write;
    assign illegal_op = rst_n & (state_q == S_DECODE) & ~op_supported(opcode);
    assign state      = state_q;

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// tb/tb_mips_multicycle_controller.sv - scoreboard bench for the multicycle MIPS control FSM
module tb_mips_multicycle_controller;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] BAD  = 6'b111111;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, pc_en, iord, mem_req, mem_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal_op;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctrl;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];
    int    n_vec;
    int    n_err;

    mips_multicycle_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_en      (pc_en),
        .iord       (iord),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_src     (pc_src),
        .illegal_op (illegal_op),
        .state      (state)
    );

    always #5 clk = ~clk;

    // Expected control word from the state table:
    // {ir_write,pc_en,iord,mem_req,mem_write,reg_write,reg_dst,mem_to_reg,alu_src_a,alu_src_b,alu_op,pc_src,illegal_op}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] s, input logic r, input logic [5:0] op,
                                             input logic z, input logic mr);
        logic ir, pcw, br, pcen, io, mreq, mw, rw, rd, m2r, asa, ill;
        logic [1:0] asb, aop, psrc;
        {ir, pcw, br, io, mreq, mw, rw, rd, m2r, asa, ill} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (s)
            4'd0:  begin mreq = 1; asb = 2'b01; ir = mr; pcw = mr; end
            4'd1:  begin asb = 2'b11;
                         ill = !(op == RT || op == LW || op == SW || op == BEQ || op == ADDI || op == JMP); end
            4'd2:  begin asa = 1; asb = 2'b10; end
            4'd3:  begin mreq = 1; io = 1; end
            4'd4:  begin rw = 1; m2r = 1; end
            4'd5:  begin mreq = 1; io = 1; mw = 1; end
            4'd6:  begin asa = 1; aop = 2'b10; end
            4'd7:  begin rw = 1; rd = 1; end
            4'd8:  begin asa = 1; aop = 2'b01; br = 1; psrc = 2'b01; end
            4'd9:  begin asa = 1; asb = 2'b10; end
            4'd10: begin rw = 1; end
            4'd11: begin psrc = 2'b10; pcw = 1; end
            default: begin end
        endcase
        pcen = pcw | (br & z);
        if (!r) {ir, pcen, mreq, mw, rw, ill} = '0;
        return {ir, pcen, io, mreq, mw, rw, rd, m2r, asa, asb, aop, psrc, ill};
    endfunction

    // One cycle of stimulus: drive inputs just after the edge, queue what the DUT must show
    task automatic step(input string tag, input logic r, input logic [5:0] op,
                        input logic z, input logic mr, input logic [3:0] es);
        exp_t e;
        @(posedge clk);
        #1;
        rst_n     = r;
        opcode    = op;
        zero      = z;
        mem_ready = mr;
        e.st   = es;
        e.ctrl = exp_ctrl(es, r, op, z, mr);
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    // Monitor: mid-cycle, pop one expectation and compare against the live outputs
    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t  e;
            string t;
            logic [15:0] act;
            e = sb_q.pop_front();
            t = tag_q.pop_front();
            act = {ir_write, pc_en, iord, mem_req, mem_write, reg_write, reg_dst, mem_to_reg,
                   alu_src_a, alu_src_b, alu_op, pc_src, illegal_op};
            n_vec++;
            if (state !== e.st || act !== e.ctrl) begin
                n_err++;
                $display("FAIL %s: state=%0d ctrl=%b, expected state=%0d ctrl=%b",
                         t, state, act, e.st, e.ctrl);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; rst_n = 0; opcode = RT; zero = 0; mem_ready = 1;
        n_vec = 0; n_err = 0;

        step("rst_hold", 0, LW, 0, 1, 0);
        // lw, opcode changed after DECODE must be ignored
        step("lw_fetch",  1, LW,  0, 1, 0);
        step("lw_dec",    1, LW,  0, 1, 1);
        step("lw_adr",    1, SW,  0, 1, 2);
        step("lw_rd",     1, SW,  0, 1, 3);
        step("lw_wb",     1, JMP, 0, 1, 4);
        // sw with three memory wait cycles
        step("sw_fetch",  1, SW, 0, 1, 0);
        step("sw_dec",    1, SW, 0, 1, 1);
        step("sw_adr",    1, LW, 0, 1, 2);
        step("sw_wr0",    1, LW, 0, 0, 5);
        step("sw_wr1",    1, LW, 0, 0, 5);
        step("sw_wr2",    1, LW, 0, 0, 5);
        step("sw_wr3",    1, LW, 0, 1, 5);
        // R-type with a fetch wait cycle
        step("rt_fwait",  1, RT, 0, 0, 0);
        step("rt_fetch",  1, RT, 0, 1, 0);
        step("rt_dec",    1, RT, 0, 1, 1);
        step("rt_exe",    1, LW, 0, 0, 6);
        step("rt_wb",     1, LW, 0, 0, 7);
        // addi
        step("addi_fetch", 1, ADDI, 0, 1, 0);
        step("addi_dec",   1, ADDI, 0, 1, 1);
        step("addi_ex",    1, ADDI, 0, 1, 9);
        step("addi_wb",    1, ADDI, 0, 1, 10);
        // beq taken, then not taken, then zero toggling ignored outside BRANCH
        step("beq1_fetch", 1, BEQ, 0, 1, 0);
        step("beq1_dec",   1, BEQ, 1, 1, 1);
        step("beq1_br",    1, BEQ, 1, 1, 8);
        step("beq0_fetch", 1, BEQ, 1, 1, 0);
        step("beq0_dec",   1, BEQ, 0, 1, 1);
        step("beq0_br",    1, BEQ, 0, 1, 8);
        // jump
        step("j_fetch",   1, JMP, 0, 1, 0);
        step("j_dec",     1, JMP, 0, 1, 1);
        step("j_jump",    1, JMP, 0, 0, 11);
        // illegal opcode
        step("ill_fetch", 1, BAD, 0, 1, 0);
        step("ill_dec",   1, BAD, 0, 1, 1);
        step("ill_back",  1, BAD, 0, 1, 0);
        // reset asserted while stalled in MEMRD
        step("rlw_dec",   1, LW, 0, 1, 1);
        step("rlw_adr",   1, LW, 0, 1, 2);
        step("rlw_rd",    1, LW, 0, 0, 3);
        step("rst_mid",   0, LW, 1, 1, 0);
        step("rst_hold2", 0, LW, 1, 1, 0);
        step("rst_rel",   1, LW, 0, 1, 0);
        step("post_dec",  1, JMP, 0, 1, 1);
        step("post_jump", 1, JMP, 0, 1, 11);
        step("post_fetch", 1, RT, 0, 1, 0);

        @(negedge clk);
        @(negedge clk);
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
